// File: rtl/bounce_counter_if.sv
// rtl/bounce_counter_if.sv - control/status bundle for bounce_counter
//
// Groups the counter's control inputs and status outputs.
//   master (driver side): enable, mode, lo, hi, load, load_val -> ; <- out, dir, turn, wrap, cfg_err
//   slave  (counter side): the reverse directions
// Parameter WIDTH must match the WIDTH of the counter it connects to.
interface bounce_counter_if #(
    parameter int WIDTH = 4
) ();
    logic             enable;
    logic [1:0]       mode;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] out;
    logic             dir;
    logic             turn;
    logic             wrap;
    logic             cfg_err;

    modport master (
        output enable, mode, lo, hi, load, load_val,
        input  out, dir, turn, wrap, cfg_err
    );

    modport slave (
        input  enable, mode, lo, hi, load, load_val,
        output out, dir, turn, wrap, cfg_err
    );
endinterface

// File: rtl/bounce_counter.sv
// rtl/bounce_counter.sv - up/down/bounce counter with run-time bounds
//
// Counts between lo and hi (inclusive) in bounce, wrap-up or wrap-down mode.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous, active-high
//   bus    - bounce_counter_if.slave:
//            enable, mode (00 bounce, 01 wrap-up, 10 wrap-down, 11 hold),
//            lo, hi, load, load_val in; out, dir, turn, wrap (registered),
//            cfg_err (combinational, lo >= hi) out
// Optional feature: define BOUNCE_CNT_PRESCALE_EN to step only once every
// PRESCALE enabled cycles; otherwise every enabled cycle is a step.
module bounce_counter #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic               clock,
    input  logic               reset,
    bounce_counter_if.slave    bus
);
    typedef logic [WIDTH-1:0] cnt_t;

    localparam logic [1:0] MODE_BOUNCE    = 2'b00;
    localparam logic [1:0] MODE_WRAP_UP   = 2'b01;
    localparam logic [1:0] MODE_WRAP_DOWN = 2'b10;
    localparam logic [1:0] MODE_HOLD      = 2'b11;

    cnt_t out_q, out_d;
    logic dir_q, dir_d;
    logic turn_q, turn_d;
    logic wrap_q, wrap_d;

    logic tick;
    logic cfg_err;
    logic bounce_down;
    cnt_t out_inc;
    cnt_t out_dec;

    assign cfg_err = (bus.lo >= bus.hi);
    assign out_inc = out_q + cnt_t'(1);
    assign out_dec = out_q - cnt_t'(1);

`ifdef BOUNCE_CNT_PRESCALE_EN
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q, ps_d;

    // Prescaler counts enabled cycles independent of mode; load restarts it.
    always_comb begin
        tick = bus.enable && (ps_q == PS_LAST);
        ps_d = ps_q;
        if (bus.load) begin
            ps_d = '0;
        end else if (bus.enable) begin
            ps_d = tick ? '0 : ps_q + PS_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end
`else
    logic unused_prescale;
    assign unused_prescale = (PRESCALE > 0);

    always_comb begin
        tick = bus.enable;
    end
`endif

    always_comb begin
        out_d       = out_q;
        dir_d       = dir_q;
        turn_d      = 1'b0;
        wrap_d      = 1'b0;
        bounce_down = dir_q;

        if (bus.load) begin
            if (bus.load_val < bus.lo) begin
                out_d = bus.lo;
            end else if (bus.load_val > bus.hi) begin
                out_d = bus.hi;
            end else begin
                out_d = bus.load_val;
            end
            dir_d = (bus.mode == MODE_WRAP_DOWN);
        end else if (cfg_err) begin
            out_d = bus.lo;
            dir_d = 1'b0;
        end else if (tick && (bus.mode != MODE_HOLD)) begin
            if ((out_q < bus.lo) || (out_q > bus.hi)) begin
                // Re-enter the window at the bound the mode starts from.
                out_d = (bus.mode == MODE_WRAP_DOWN) ? bus.hi : bus.lo;
                dir_d = (bus.mode == MODE_WRAP_DOWN);
            end else begin
                case (bus.mode)
                    MODE_BOUNCE: begin
                        // Already sitting on the bound we are heading for
                        // (after a load or mode change): reflect off it instead
                        // of stepping past it.
                        if (!dir_q && (out_q == bus.hi)) begin
                            bounce_down = 1'b1;
                        end else if (dir_q && (out_q == bus.lo)) begin
                            bounce_down = 1'b0;
                        end
                        if (bounce_down) begin
                            out_d = out_dec;
                            dir_d = 1'b1;
                            if (out_dec == bus.lo) begin
                                dir_d  = 1'b0;
                                turn_d = 1'b1;
                            end
                        end else begin
                            out_d = out_inc;
                            dir_d = 1'b0;
                            if (out_inc == bus.hi) begin
                                dir_d  = 1'b1;
                                turn_d = 1'b1;
                            end
                        end
                    end
                    MODE_WRAP_UP: begin
                        dir_d = 1'b0;
                        if (out_q == bus.hi) begin
                            out_d  = bus.lo;
                            wrap_d = 1'b1;
                        end else begin
                            out_d = out_inc;
                        end
                    end
                    MODE_WRAP_DOWN: begin
                        dir_d = 1'b1;
                        if (out_q == bus.lo) begin
                            out_d  = bus.hi;
                            wrap_d = 1'b1;
                        end else begin
                            out_d = out_dec;
                        end
                    end
                    default: begin
                        out_d = out_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_q  <= '0;
            dir_q  <= 1'b0;
            turn_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            dir_q  <= dir_d;
            turn_q <= turn_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.out     = out_q;
    assign bus.dir     = dir_q;
    assign bus.turn    = turn_q;
    assign bus.wrap    = wrap_q;
    assign bus.cfg_err = cfg_err;
endmodule

// File: tb/tb_bounce_counter.sv
// tb/tb_bounce_counter.sv - scoreboard testbench for bounce_counter
module tb_bounce_counter;
    localparam int WIDTH    = 4;
    localparam int PRESCALE = 3;
`ifdef BOUNCE_CNT_PRESCALE_EN
    localparam int STEP_CYC = PRESCALE;
`else
    localparam int STEP_CYC = 1;
`endif

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    bounce_counter_if #(.WIDTH(WIDTH)) bus ();

    bounce_counter #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int out;
        int dir;
        int turn;
        int wrap;
    } exp_t;

    exp_t exp_q[$];
    int   m_out, m_dir, m_ps;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: advance one clock edge from the current inputs.
    task automatic model_push();
        exp_t e;
        int lo, hi, lv, md, en, ld, tk, d;
        lo = int'(bus.lo); hi = int'(bus.hi); lv = int'(bus.load_val);
        md = int'(bus.mode); en = int'(bus.enable); ld = int'(bus.load);
`ifdef BOUNCE_CNT_PRESCALE_EN
        tk = (en == 1 && m_ps == PRESCALE - 1) ? 1 : 0;
        if (ld == 1) m_ps = 0;
        else if (en == 1) m_ps = (tk == 1) ? 0 : m_ps + 1;
`else
        tk = en;
`endif
        e.turn = 0;
        e.wrap = 0;
        if (ld == 1) begin
            m_out = (lv < lo) ? lo : ((lv > hi) ? hi : lv);
            m_dir = (md == 2) ? 1 : 0;
        end else if (lo >= hi) begin
            m_out = lo;
            m_dir = 0;
        end else if (tk == 1 && md != 3) begin
            if (m_out < lo || m_out > hi) begin
                m_out = (md == 2) ? hi : lo;
                m_dir = (md == 2) ? 1 : 0;
            end else if (md == 1) begin
                m_dir = 0;
                if (m_out == hi) begin m_out = lo; e.wrap = 1; end
                else m_out = m_out + 1;
            end else if (md == 2) begin
                m_dir = 1;
                if (m_out == lo) begin m_out = hi; e.wrap = 1; end
                else m_out = m_out - 1;
            end else begin
                d = m_dir;
                if (d == 0 && m_out == hi) d = 1;
                else if (d == 1 && m_out == lo) d = 0;
                m_out = (d == 1) ? m_out - 1 : m_out + 1;
                m_dir = d;
                if (d == 0 && m_out == hi) begin m_dir = 1; e.turn = 1; end
                if (d == 1 && m_out == lo) begin m_dir = 0; e.turn = 1; end
            end
        end
        e.out = m_out;
        e.dir = m_dir;
        exp_q.push_back(e);
    endtask

    // One clock: push expectation, check cfg_err, let the edge happen, compare.
    task automatic cycle(input string tag);
        exp_t e;
        model_push();
        #1;
        check({tag, "_cfg_err"}, 32'(bus.cfg_err), (bus.lo >= bus.hi) ? 32'd1 : 32'd0);
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_out"},  32'(bus.out),  32'(e.out));
            check({tag, "_dir"},  32'(bus.dir),  32'(e.dir));
            check({tag, "_turn"}, 32'(bus.turn), 32'(e.turn));
            check({tag, "_wrap"}, 32'(bus.wrap), 32'(e.wrap));
        end
    endtask

    task automatic step(input string tag);
        for (int k = 0; k < STEP_CYC; k++) cycle(tag);
    endtask

    task automatic do_load(input int v);
        bus.load     = 1'b1;
        bus.load_val = 4'(v);
        cycle("load");
        bus.load     = 1'b0;
    endtask

    task automatic set_cfg(input int md, input int lo, input int hi);
        bus.mode = 2'(md);
        bus.lo   = 4'(lo);
        bus.hi   = 4'(hi);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out"},  32'(bus.out),  32'd0);
        check({tag, "_dir"},  32'(bus.dir),  32'd0);
        check({tag, "_turn"}, 32'(bus.turn), 32'd0);
        check({tag, "_wrap"}, 32'(bus.wrap), 32'd0);
    endtask

    initial begin
        int p;
        int wu_out[5];
        int wu_wrap[5];
        int wd_out[4];

        wu_out  = '{3, 4, 5, 6, 3};
        wu_wrap = '{0, 0, 0, 0, 1};
        wd_out  = '{5, 4, 3, 6};

        reset = 1'b1;
        bus.enable = 1'b1;
        bus.load = 1'b0;
        bus.load_val = '0;
        set_cfg(0, 0, 15);
        m_out = 0; m_dir = 0; m_ps = 0;
        #3;
        check_zero("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Bounce 0..15..0 for 40 steps
        for (int i = 1; i <= 40; i++) begin
            step("bounce");
            p = i % 30;
            check("bounce_seq", 32'(bus.out), 32'((p <= 15) ? p : 30 - p));
            check("bounce_seq_turn", 32'(bus.turn), (p == 15 || p == 0) ? 32'd1 : 32'd0);
            check("bounce_seq_dir", 32'(bus.dir), (p >= 15) ? 32'd1 : 32'd0);
        end

        // Wrap-up 3..6; out=10 is out of range so the first step lands on lo
        set_cfg(1, 3, 6);
        for (int i = 0; i < 5; i++) begin
            step("wrap_up");
            check("wrap_up_seq", 32'(bus.out), 32'(wu_out[i]));
            check("wrap_up_seq_wrap", 32'(bus.wrap), 32'(wu_wrap[i]));
        end

        // Wrap-down with clamped load
        set_cfg(2, 3, 6);
        do_load(9);
        check("wrap_down_load", 32'(bus.out), 32'd6);
        check("wrap_down_load_dir", 32'(bus.dir), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step("wrap_down");
            check("wrap_down_seq", 32'(bus.out), 32'(wd_out[i]));
            check("wrap_down_seq_wrap", 32'(bus.wrap), (i == 3) ? 32'd1 : 32'd0);
        end

        // Bad bounds: cfg_err immediate, out takes lo on the next edge
        set_cfg(0, 7, 5);
        #1;
        check("cfg_err_comb", 32'(bus.cfg_err), 32'd1);
        cycle("cfg_err");
        check("cfg_err_out", 32'(bus.out), 32'd7);

        // Enable toggling 1,0,1
        set_cfg(0, 0, 15);
        do_load(2);
        step("en1");
        check("en_step1", 32'(bus.out), 32'd3);
        bus.enable = 1'b0;
        for (int k = 0; k < STEP_CYC; k++) cycle("en0");
        check("en_hold", 32'(bus.out), 32'd3);
        bus.enable = 1'b1;
        step("en1b");
        check("en_step2", 32'(bus.out), 32'd4);

        // Hold mode
        bus.mode = 2'b11;
        step("hold");
        step("hold");
        check("hold_out", 32'(bus.out), 32'd4);
        check("hold_turn", 32'(bus.turn), 32'd0);

        // Reach out=9, dir=1, then asynchronous reset
        set_cfg(0, 0, 10);
        do_load(8);
        step("pre_rst");
        step("pre_rst");
        step("pre_rst");
        check("pre_rst_out", 32'(bus.out), 32'd9);
        check("pre_rst_dir", 32'(bus.dir), 32'd1);
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        m_out = 0; m_dir = 0; m_ps = 0;
        exp_q.delete();
        #2;
        reset = 1'b0;
        set_cfg(0, 0, 15);
        step("post_rst");
        check("post_rst_out", 32'(bus.out), 32'd1);

        // Bound shrink below current value
        do_load(12);
        bus.hi = 4'd8;
        step("shrink");
        check("shrink_out", 32'(bus.out), 32'd0);
        check("shrink_dir", 32'(bus.dir), 32'd0);
        check("shrink_turn", 32'(bus.turn), 32'd0);

`ifdef BOUNCE_CNT_PRESCALE_EN
        // Prescaler: step every 3rd enabled cycle, enable gaps delay it,
        // load restarts the period.
        set_cfg(1, 0, 15);
        do_load(0);
        cycle("ps"); cycle("ps");
        check("ps_wait", 32'(bus.out), 32'd0);
        cycle("ps");
        check("ps_step", 32'(bus.out), 32'd1);
        cycle("ps");
        bus.enable = 1'b0;
        cycle("ps_gap"); cycle("ps_gap");
        bus.enable = 1'b1;
        cycle("ps");
        check("ps_gap_wait", 32'(bus.out), 32'd1);
        cycle("ps");
        check("ps_gap_step", 32'(bus.out), 32'd2);
        cycle("ps");
        do_load(5);
        cycle("ps"); cycle("ps");
        check("ps_load_wait", 32'(bus.out), 32'd5);
        cycle("ps");
        check("ps_load_step", 32'(bus.out), 32'd6);
`endif

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            bus.enable   = ($urandom_range(0, 3) != 0);
            bus.load     = ($urandom_range(0, 7) == 0);
            bus.load_val = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) begin
                bus.mode = 2'($urandom_range(0, 3));
                bus.lo   = 4'($urandom_range(0, 15));
                bus.hi   = 4'($urandom_range(0, 15));
            end
            cycle("rand");
        end
        bus.load = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bounce_counter.md
# bounce_counter

Parametrised up/down/bounce counter with programmable bounds: the next-generation counter for the board demo designs. It counts between run-time bounds `lo` and `hi` in bounce (ping-pong), wrap-up or wrap-down mode, and supports synchronous load, count enable and turnaround/wrap event pulses. With `lo=0`, `hi=15` and bounce mode it produces the 4-bit sequence 0,1,…,15,14,…,0,1,….

## Interface
- `WIDTH`, 4: counter width in bits (≥2).
- `PRESCALE`, 1: enabled cycles per count step; used only when `BOUNCE_CNT_PRESCALE_EN` is defined (≥1).
- `clock` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: count enable; no step when low.
- `mode` in 2: 00 bounce, 01 wrap-up, 10 wrap-down, 11 hold.
- `lo` in WIDTH: lower bound, inclusive.
- `hi` in WIDTH: upper bound, inclusive.
- `load` in 1: synchronous load strobe.
- `load_val` in WIDTH: load value.
- `out` out WIDTH: count value, registered.
- `dir` out 1: current direction, 0 up, 1 down; registered.
- `turn` out 1: one-cycle pulse in bounce mode when `out` reaches `hi` or `lo` and `dir` flips; registered.
- `wrap` out 1: one-cycle pulse when a wrap mode jumps bound-to-bound; registered.
- `cfg_err` out 1: combinational, high when `lo >= hi`.

## Operation
- Reset values: `out=0`, `dir=0`, `turn=0`, `wrap=0`, prescaler=0.
- Priority per edge: `reset` > `load` > `cfg_err` > step > idle.
- `load`: `out` takes `load_val` clamped to [`lo`,`hi`]. `dir` is 0, except in wrap-down mode where it is 1. Prescaler clears. No pulses. Applies regardless of `enable`.
- `cfg_err` high (and no load): `out` takes `lo`, `dir` takes 0, no pulses.
- Step occurs when `tick` is high and the mode is not hold. `tick` is `enable` (see Configuration).
- Out-of-range step: if `out<lo` or `out>hi`, `out` takes `lo` (`hi` in wrap-down mode) and `dir` is set for the mode. No pulses.
- Bounce, `dir=0`:
  - `out` takes `out+1`.
  - If `out+1==hi`: `dir` takes 1 and `turn` pulses.
- Bounce, `dir=1`:
  - `out` takes `out-1`.
  - If `out-1==lo`: `dir` takes 0 and `turn` pulses.
- Wrap-up: `dir` forced 0. If `out==hi`, `out` takes `lo` and `wrap` pulses; otherwise `out+1`.
- Wrap-down: `dir` forced 1. If `out==lo`, `out` takes `hi` and `wrap` pulses; otherwise `out-1`.
- Hold mode or no `tick`: `out` and `dir` keep their values; `turn=0`, `wrap=0`.
- Mode change mid-count:
  - Bounce resumes from the current `out`/`dir`.
  - Wrap modes force `dir` on their first step.
- Arithmetic is WIDTH-bit unsigned. Natural overflow cannot occur because bounds are checked before ±1.
- Bound changes take effect on the next edge.

## Timing
- `out`, `dir`, `turn` and `wrap` update one edge after a qualifying step; `turn`/`wrap` are high for exactly the cycle in which `out` shows the bound value.
- `load` latency is 1 cycle. `cfg_err` has zero latency (combinational).
- Reset mid-count clears everything immediately (asynchronous); the first step after release moves 0→1.
- Bounce period is `2*(hi-lo)` steps; wrap period is `hi-lo+1` steps.

## Configuration
- `BOUNCE_CNT_PRESCALE_EN` defined:
  - A prescaler counts enabled cycles 0…`PRESCALE`-1.
  - `tick` is high on the enabled cycle where the prescaler equals `PRESCALE`-1; the prescaler then returns to 0.
  - The prescaler holds when `enable` is low and clears on `reset`/`load`.
  - `PRESCALE=1` is equivalent to undefined.
- Undefined: no prescaler logic, `tick = enable`, and `PRESCALE` is ignored.

## Test plan
- Bounce: `WIDTH=4`, `lo=0`, `hi=15`, `enable=1`, 40 cycles after reset.
  - `out` follows 0,1,…,15,14,…,0,1,….
  - `turn` is high when `out`=15 and when `out`=0 (the return).
  - `dir` is 1 from `out`=15 until `out`=0.
- Wrap-up: `lo=3`, `hi=6`.
  - `out` follows 3,4,5,6,3.
  - `wrap` is high with the second 3.
- Wrap-down: `lo=3`, `hi=6`, `load_val=9`.
  - `load` gives `out`=6 (clamped), then 5,4,3,6 with `wrap` on the second 6.
  - `lo=7`, `hi=5` gives `cfg_err=1` and `out`=7 on the next edge.
- Enable/hold:
  - `enable` toggled 1,0,1: `out` advances only on enabled cycles.
  - `mode=11`: `out` frozen, no pulses.
  - Assert `reset` with `out`=9, `dir`=1: all outputs 0 asynchronously, next step gives `out`=1.
- Prescale, macro defined, `PRESCALE=3`, `enable=1`:
  - `out` steps every 3rd cycle.
  - With `enable` low for 2 cycles mid-period, the step is delayed by 2 cycles.
  - `load` restarts the 3-cycle period.
- Bound shrink: `out`=12 in bounce, then `hi` changes to 8. The next step gives `out`=`lo`, `dir=0`, no `turn`.
